// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared write-back definitions: requester indices, counter width, request bundle.
package regfile_wb_arbiter_pkg;

  // Requester indices into the valid/ready/grant vectors
  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_LSU = 1;
  localparam int unsigned REQ_MDU = 2;
  localparam int unsigned REQ_NUM = 3;

  // Starvation counter width; holds STARVE_LIMIT up to 15
  localparam int unsigned STARVE_W = 4;

  typedef logic [REQ_NUM-1:0]  req_vec_t;
  typedef logic [STARVE_W-1:0] starve_cnt_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_req_t;

  // Saturating increment of a starvation counter
  function automatic starve_cnt_t sat_inc(input starve_cnt_t cnt, input starve_cnt_t lim);
    if (cnt >= lim) begin
      return lim;
    end
    return cnt + starve_cnt_t'(1);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_prio_select.sv
// Fixed-priority one-hot selector with promotion override. Index 0 has the highest
// base priority; any promoted valid requester beats every non-promoted one.
module wb_prio_select
  import regfile_wb_arbiter_pkg::*;
(
  input  logic [REQ_NUM-1:0] valid,
  input  logic [REQ_NUM-1:0] promoted,
  output logic [REQ_NUM-1:0] grant
);

  logic [REQ_NUM-1:0] prom_valid;
  logic [REQ_NUM-1:0] cand;

  // Restrict the candidate set to promoted requesters when any exist
  always_comb begin
    prom_valid = valid & promoted;
    cand       = (|prom_valid) ? prom_valid : valid;
  end

  // Pick the lowest-index candidate; scanning downward lets the lowest index win
  always_comb begin
    grant = '0;
    for (int i = int'(REQ_NUM) - 1; i >= 0; i--) begin
      if (cand[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: shares the register-file write port among ALU, LSU and MDU.
// Fixed priority ALU > LSU > MDU with per-requester starvation promotion; the winner
// is registered onto the register-file write inputs one cycle after the grant.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_hold,
  input  logic        alu_valid,
  input  logic        lsu_valid,
  input  logic        mdu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [4:0]  lsu_addr,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] alu_data,
  input  logic [31:0] lsu_data,
  input  logic [31:0] mdu_data,
  output logic        alu_ready,
  output logic        lsu_ready,
  output logic        mdu_ready,
  output logic        RegWE,
  output logic [4:0]  write_addr,
  output logic [31:0] write_data,
  output logic [4:0]  collision_addr,
  output logic [2:0]  starve_flag
);

  localparam starve_cnt_t Lim = starve_cnt_t'(STARVE_LIMIT);

  req_vec_t    valid;
  req_vec_t    promoted;
  req_vec_t    sel;
  req_vec_t    grant;
  wb_req_t     req [REQ_NUM];
  wb_req_t     win;
  logic        any_grant;
  starve_cnt_t cnt_q [REQ_NUM];
  starve_cnt_t cnt_d [REQ_NUM];

  logic        we_q;
  logic [4:0]  addr_q;
  logic [31:0] data_q;
  logic [4:0]  coll_q;

  assign valid[REQ_ALU] = alu_valid;
  assign valid[REQ_LSU] = lsu_valid;
  assign valid[REQ_MDU] = mdu_valid;

  assign req[REQ_ALU] = '{addr: alu_addr, data: alu_data};
  assign req[REQ_LSU] = '{addr: lsu_addr, data: lsu_data};
  assign req[REQ_MDU] = '{addr: mdu_addr, data: mdu_data};

  // Promotion: a still-valid requester whose counter has reached the limit
  always_comb begin
    promoted = '0;
    for (int i = 0; i < int'(REQ_NUM); i++) begin
      promoted[i] = valid[i] && (cnt_q[i] == Lim);
    end
  end

  wb_prio_select u_prio_select (
    .valid    (valid),
    .promoted (promoted),
    .grant    (sel)
  );

  // Gate grants off during reset and pipeline freeze
  always_comb begin
    grant = (rst && !wb_hold) ? sel : '0;
    any_grant = |grant;
  end

  assign alu_ready   = grant[REQ_ALU];
  assign lsu_ready   = grant[REQ_LSU];
  assign mdu_ready   = grant[REQ_MDU];
  assign starve_flag = promoted;

  // Winning request mux; zero when nothing is granted
  always_comb begin
    win = '0;
    for (int i = 0; i < int'(REQ_NUM); i++) begin
      if (grant[i]) begin
        win = req[i];
      end
    end
  end

  // Counter next state: frozen on hold, cleared on grant or idle, else saturating count
  always_comb begin
    for (int i = 0; i < int'(REQ_NUM); i++) begin
      cnt_d[i] = cnt_q[i];
      if (!wb_hold) begin
        if (!valid[i] || grant[i]) begin
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = sat_inc(cnt_q[i], Lim);
        end
      end
    end
  end

  // Starvation counter registers
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(REQ_NUM); i++) begin
      if (!rst) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Output stage: one entry, drained every cycle; r0 writes are granted but never enabled
  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      coll_q <= '0;
    end else begin
      we_q   <= any_grant && (win.addr != 5'd0);
      coll_q <= win.addr;
      if (any_grant) begin
        addr_q <= win.addr;
        data_q <= win.data;
      end
    end
  end

  // Drop an in-flight write as soon as reset is asserted
  assign RegWE          = we_q && rst;
  assign write_addr     = addr_q;
  assign write_data     = data_q;
  assign collision_addr = coll_q;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

- Shares the register file's single write port among three write-back requesters: ALU, load/store unit (LSU) and multiply/divide unit (MDU).
- Sits between the execute/memory stages and the register file write port.
- Selects one requester per cycle by fixed priority with a starvation guard, then registers the winning write onto the register-file write inputs (write enable, write address, write data).
- Also drives the register file's hazard-tracking address input, so stall detection sees every write in grant order.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive denied cycles after which a waiting requester is promoted; legal 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- wb_hold  in  1  pipeline freeze; no grants while high
- alu_valid / lsu_valid / mdu_valid  in  1 each  write request
- alu_addr / lsu_addr / mdu_addr  in  5 each  destination register
- alu_data / lsu_data / mdu_data  in  32 each  write value
- alu_ready / lsu_ready / mdu_ready  out  1 each  grant; combinational
- RegWE  out  1  register-file write enable, registered
- write_addr  out  5  register-file write address, registered
- write_data  out  32  register-file write data, registered
- collision_addr  out  5  granted destination; 0 when idle or for r0 writes
- starve_flag  out  3  {mdu,lsu,alu}; promotion active this cycle

## Operation
- Handshake:
  - A transfer occurs when X_valid && X_ready.
  - While X_valid is high, the requester must hold X_valid, X_addr and X_data stable until the transfer.
  - ready is never asserted without valid.
- Base priority: ALU > LSU > MDU.
- At most one ready is high per cycle.
- Starvation counter, one per requester:
  - Increments, saturating at STARVE_LIMIT, each cycle the requester is valid but not granted.
  - Clears on grant or when valid is low.
- Promotion:
  - A requester is promoted when its counter equals STARVE_LIMIT.
  - Promoted requesters beat all non-promoted ones.
  - Among several promoted requesters, base priority applies.
  - starve_flag[i] = promoted[i].
- wb_hold high:
  - All ready are low.
  - Counters do not change.
  - RegWE = 0 on the next cycle.
- r0 writes:
  - Granted normally; the requester is released.
  - RegWE stays 0 for that write.
  - collision_addr is 0.
- Same destination from two requesters in one cycle:
  - Only one is granted.
  - Writes reach the register file in grant order; no merging.
- The output register holds exactly one entry and drains every cycle, so there is no backpressure from the register file.
- FSM: none beyond the counters. The arbitration state is the three counters; the output stage is a single valid bit (RegWE).

## Timing
- Grant in cycle t: RegWE, write_addr and write_data are valid in cycle t+1, for exactly one cycle. The register file commits at the end of t+1.
- Cycles with no grant: RegWE = 0 in t+1; write_addr and write_data hold their previous values.
- collision_addr is registered alongside RegWE, appearing in cycle t+1 so it enters the register file's hazard buffer the same cycle the write occurs.
- Reset (rst = 0 at a clock edge):
  - Outputs: RegWE = 0, write_addr = 0, write_data = 0, collision_addr = 0.
  - Internal: all counters = 0.
  - All ready are forced low while rst = 0.
- Reset mid-operation:
  - An in-flight output write is dropped.
  - Requesters must re-present after reset release.
- First cycle after rst rises: arbitration is live, and a grant is possible in that cycle.
- Worst-case wait for any continuously valid requester: STARVE_LIMIT + 2 non-hold cycles.

## Structure
- Shared package, alongside the existing ALU/pause defines:
  - Requester indices: REQ_ALU = 0, REQ_LSU = 1, REQ_MDU = 2.
  - REQ_NUM = 3.
  - Counter width STARVE_W = 4.
- Sub-module wb_prio_select: purely combinational.
  - Inputs: valid[2:0], promoted[2:0].
  - Output: one-hot grant[2:0].
  - Reused by the future second write-port arbiter.
- The top level holds the counters, the output register and the r0 suppression.

## Test plan
1. Only alu_valid, alu_addr = 5, alu_data = 0xDEADBEEF -> alu_ready same cycle; next cycle RegWE = 1, write_addr = 5, write_data = 0xDEADBEEF, collision_addr = 5.
2. ALU, LSU and MDU all valid continuously, STARVE_LIMIT = 4 -> ALU granted cycles 0-3; LSU promoted and granted cycle 4; MDU granted by cycle 6; starve_flag pulses observed.
3. LSU writes addr 0, data 0x1234 -> lsu_ready = 1; next cycle RegWE = 0, collision_addr = 0.
4. ALU and MDU both target r7 (0x11 and 0x22) in the same cycle -> ALU write first, MDU next cycle; r7 ends as 0x22.
5. wb_hold held 3 cycles with all requesters valid -> no ready, no RegWE, counters frozen; grants resume immediately when hold drops.
6. rst = 0 asserted in the cycle after a grant -> RegWE = 0 and all outputs 0 following that edge; no register-file write occurs.
